// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the WB stage (primary)
// and a queued auxiliary result path (mult/div, secondary). Aux results wait in a small FIFO
// and drain on cycles without a WB write. A starvation counter raises a one-cycle stall so
// that a blocked FIFO head always retires. All rf_* outputs are registered (1-cycle latency).
// Optional feature macro: ARB_SCOREBOARD_EN enables the per-register pending_mask_o tracking.
module wb_port_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_reg_i,
  input  logic [31:0]              wb_data_i,
  input  logic                     aux_valid_i,
  output logic                     aux_ready_o,
  input  logic [4:0]               aux_reg_i,
  input  logic [31:0]              aux_data_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     stall_req_o,
  output logic [$clog2(DEPTH):0]   aux_pending_o,
  output logic [31:0]              pending_mask_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {SelNone, SelWb, SelAux} sel_e;

  // FIFO storage and control state
  logic [4:0]      reg_mem_q  [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            stall_q, stall_d;

  // Registered write-port outputs
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [31:0]     rf_wdata_q, rf_wdata_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        wb_req;
  logic        blocked;
  logic [4:0]  head_reg;
  logic [31:0] head_data;
  sel_e        sel;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CntW'(DEPTH));
  // Ready depends on occupancy only, so a push into a full FIFO cannot happen.
  assign aux_ready_o = ~fifo_full;
  assign push        = aux_valid_i & ~fifo_full;
  // A write to x0 is no request at all.
  assign wb_req      = wb_valid_i & (wb_reg_i != 5'd0);
  assign head_reg    = reg_mem_q[rptr_q];
  assign head_data   = data_mem_q[rptr_q];

  // Write-port source selection: forced drain, then WB, then opportunistic drain.
  always_comb begin
    sel = SelNone;
    if (stall_q && !fifo_empty) begin
      sel = SelAux;
    end else if (wb_req) begin
      sel = SelWb;
    end else if (!fifo_empty) begin
      sel = SelAux;
    end
  end

  assign pop     = (sel == SelAux);
  assign blocked = (sel == SelWb) & ~fifo_empty;

  // Next write-port values; address/data hold when nothing is written.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (sel)
      SelWb: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_reg_i;
        rf_wdata_d = wb_data_i;
      end
      SelAux: begin
        // A head targeting x0 is still popped but produces no write.
        if (head_reg != 5'd0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = head_reg;
          rf_wdata_d = head_data;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push/pop leaves occupancy unchanged.
  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation tracking: the stall is raised on the edge where the count reaches STARVE_MAX
  // and the following forced pop clears the count, so the stall lasts exactly one cycle.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (blocked) begin
      starve_d = starve_q + StW'(1);
    end
    stall_d = blocked & (starve_q == StW'(STARVE_MAX - 1));
  end

  // Control and output state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO payload storage; reset only clears the pointers, stale entries are unreachable.
  always_ff @(posedge clk_i) begin
    if (push) begin
      reg_mem_q[wptr_q]  <= aux_reg_i;
      data_mem_q[wptr_q] <= aux_data_i;
    end
  end

  assign rf_we_o       = rf_we_q;
  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign stall_req_o   = stall_q;
  assign aux_pending_o = count_q;

`ifdef ARB_SCOREBOARD_EN
  // Per-register count of queued entries keeps the mask exact when a register is queued twice.
  logic [CntW-1:0] reg_cnt_q [32];
  logic [CntW-1:0] reg_cnt_d [32];

  // Increment on push, decrement on pop; both on the same register cancel out.
  always_comb begin
    reg_cnt_d = reg_cnt_q;
    for (int r = 1; r < 32; r++) begin
      case ({push && (aux_reg_i == 5'(r)), pop && (head_reg == 5'(r))})
        2'b10:   reg_cnt_d[r] = reg_cnt_q[r] + CntW'(1);
        2'b01:   reg_cnt_d[r] = reg_cnt_q[r] - CntW'(1);
        default: reg_cnt_d[r] = reg_cnt_q[r];
      endcase
    end
  end

  // Scoreboard counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) begin
        reg_cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        reg_cnt_q[r] <= reg_cnt_d[r];
      end
    end
  end

  // Mask bit set while any queued entry targets that register; x0 never pending.
  always_comb begin
    pending_mask_o = '0;
    for (int r = 1; r < 32; r++) begin
      pending_mask_o[r] = (reg_cnt_q[r] != '0);
    end
  end
`else
  assign pending_mask_o = 32'h0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_reg;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [$clog2(DEPTH):0] aux_pending;
  logic [31:0] pending_mask;

  int checks;
  int errors;
  logic [36:0] sb [$];
  logic [31:0] mask5;

  wb_port_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wb_valid_i     (wb_valid),
    .wb_reg_i       (wb_reg),
    .wb_data_i      (wb_data),
    .aux_valid_i    (aux_valid),
    .aux_ready_o    (aux_ready),
    .aux_reg_i      (aux_reg),
    .aux_data_i     (aux_data),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .stall_req_o    (stall_req),
    .aux_pending_o  (aux_pending),
    .pending_mask_o (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    sb.push_back({r, d});
  endtask

  // Advance one cycle, sample #1 after the edge and retire any write against the scoreboard.
  task automatic tick();
    logic [37:0] exp_w;
    @(posedge clk);
    #1;
    if (rf_we) begin
      if (sb.size() != 0) exp_w = {1'b1, sb.pop_front()};
      else                exp_w = 38'h0;
      chk("rf_write", 64'({1'b1, rf_waddr, rf_wdata}), 64'(exp_w));
    end
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] r, input logic [31:0] d);
    aux_valid = v;
    aux_reg   = r;
    aux_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
`ifdef ARB_SCOREBOARD_EN
    mask5 = 32'h0000_0020;
`else
    mask5 = 32'h0;
`endif
    rst_n = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_aux(1'b0, 5'd0, 32'h0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", 64'(rf_wdata), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    chk("reset_pending", 64'(aux_pending), 64'd0);
    chk("reset_mask", 64'(pending_mask), 64'd0);
    chk("reset_ready", 64'(aux_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single aux push on an idle port
    drive_aux(1'b1, 5'd8, 32'hA5A5_A5A5);
    expect_write(5'd8, 32'hA5A5_A5A5);
    tick();
    chk("t1_pending_after_push", 64'(aux_pending), 64'd1);
    chk("t1_no_write_yet", 64'(rf_we), 64'd0);
    drive_aux(1'b0, 5'd0, 32'h0);
    tick();
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd8);
    chk("t1_pending_drained", 64'(aux_pending), 64'd0);
    tick();
    chk("t1_we_idle", 64'(rf_we), 64'd0);
    chk("t1_waddr_hold", 64'(rf_waddr), 64'd8);
    chk("t1_wdata_hold", 64'(rf_wdata), 64'hA5A5_A5A5);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: WB busy every cycle starves an aux entry until the forced drain
    drive_wb(1'b1, 5'd3, 32'h0000_3333);
    drive_aux(1'b1, 5'd9, 32'h9999_0009);
    expect_write(5'd3, 32'h0000_3333);
    tick();
    drive_aux(1'b0, 5'd0, 32'h0);
    chk("t2_pending", 64'(aux_pending), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      expect_write(5'd3, 32'h0000_3333);
      tick();
      chk($sformatf("t2_stall_c%0d", i), 64'(stall_req), 64'(i == 4));
    end
    expect_write(5'd9, 32'h9999_0009);
    tick();
    chk("t2_stall_cleared", 64'(stall_req), 64'd0);
    chk("t2_forced_waddr", 64'(rf_waddr), 64'd9);
    chk("t2_pending_zero", 64'(aux_pending), 64'd0);
    expect_write(5'd3, 32'h0000_3333);
    tick();
    chk("t2_no_restall", 64'(stall_req), 64'd0);
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("t2_we_off", 64'(rf_we), 64'd0);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: fill the FIFO behind WB, hold a third offer until space frees up
    drive_wb(1'b1, 5'd3, 32'h0000_0003);
    drive_aux(1'b1, 5'd10, 32'h1010_1010);
    chk("t3_ready_empty", 64'(aux_ready), 64'd1);
    expect_write(5'd3, 32'h0000_0003);
    tick();
    drive_aux(1'b1, 5'd11, 32'h1111_1111);
    expect_write(5'd3, 32'h0000_0003);
    tick();
    chk("t3_pending_full", 64'(aux_pending), 64'd2);
    chk("t3_ready_full", 64'(aux_ready), 64'd0);
    drive_aux(1'b1, 5'd12, 32'h1212_1212);
    expect_write(5'd3, 32'h0000_0003);
    tick();
    chk("t3_held_pending", 64'(aux_pending), 64'd2);
    expect_write(5'd3, 32'h0000_0003);
    tick();
    expect_write(5'd3, 32'h0000_0003);
    tick();
    chk("t3_stall", 64'(stall_req), 64'd1);
    chk("t3_ready_during_stall", 64'(aux_ready), 64'd0);
    expect_write(5'd10, 32'h1010_1010);
    tick();
    chk("t3_pending_after_pop", 64'(aux_pending), 64'd1);
    chk("t3_ready_after_pop", 64'(aux_ready), 64'd1);
    expect_write(5'd3, 32'h0000_0003);
    tick();
    chk("t3_third_accepted", 64'(aux_pending), 64'd2);
    drive_aux(1'b0, 5'd0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    expect_write(5'd11, 32'h1111_1111);
    tick();
    expect_write(5'd12, 32'h1212_1212);
    tick();
    chk("t3_pending_zero", 64'(aux_pending), 64'd0);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // 4: writes to x0 from both sources never assert rf_we
    drive_wb(1'b1, 5'd0, 32'hDEAD_0000);
    drive_aux(1'b1, 5'd0, 32'hBEEF_0000);
    tick();
    drive_aux(1'b0, 5'd0, 32'h0);
    chk("t4_we_wb0", 64'(rf_we), 64'd0);
    chk("t4_pending_one", 64'(aux_pending), 64'd1);
    tick();
    chk("t4_we_aux0", 64'(rf_we), 64'd0);
    chk("t4_pending_zero", 64'(aux_pending), 64'd0);
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();

    // 5: asynchronous reset with two entries queued flushes them
    drive_wb(1'b1, 5'd3, 32'h0000_0005);
    drive_aux(1'b1, 5'd20, 32'h2020_2020);
    expect_write(5'd3, 32'h0000_0005);
    tick();
    drive_aux(1'b1, 5'd21, 32'h2121_2121);
    expect_write(5'd3, 32'h0000_0005);
    tick();
    chk("t5_pending_two", 64'(aux_pending), 64'd2);
    drive_aux(1'b0, 5'd0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rf_we", 64'(rf_we), 64'd0);
    chk("t5_waddr", 64'(rf_waddr), 64'd0);
    chk("t5_wdata", 64'(rf_wdata), 64'd0);
    chk("t5_stall", 64'(stall_req), 64'd0);
    chk("t5_pending", 64'(aux_pending), 64'd0);
    chk("t5_mask", 64'(pending_mask), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_no_flushed_write", 64'(rf_we), 64'd0);
    chk("t5_pending_after", 64'(aux_pending), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6: duplicate pushes to reg 5 keep the mask bit until the last pop
    drive_wb(1'b1, 5'd3, 32'h0000_0006);
    drive_aux(1'b1, 5'd5, 32'h5555_0001);
    expect_write(5'd3, 32'h0000_0006);
    tick();
    chk("t6_mask_first", 64'(pending_mask), 64'(mask5));
    drive_aux(1'b1, 5'd5, 32'h5555_0002);
    expect_write(5'd3, 32'h0000_0006);
    tick();
    chk("t6_mask_second", 64'(pending_mask), 64'(mask5));
    chk("t6_pending_two", 64'(aux_pending), 64'd2);
    drive_aux(1'b0, 5'd0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    expect_write(5'd5, 32'h5555_0001);
    tick();
    chk("t6_mask_after_first_pop", 64'(pending_mask), 64'(mask5));
    expect_write(5'd5, 32'h5555_0002);
    tick();
    chk("t6_mask_cleared", 64'(pending_mask), 64'd0);
    chk("t6_pending_zero", 64'(aux_pending), 64'd0);
    tick();
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
